keypad_scan_ctrl: RTL

//  Scan controller for a 4x4 matrix keypad. Drives one column low at a time and samples the

---
 rtl/keypad_scan_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce
// and a valid/ready key hand-off that flags keys dropped while one is pending.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV    = 16,
    parameter int STABLE_CYC  = 8,
    parameter int RELEASE_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun
);
    localparam int MAX_AB = (SCAN_DIV > STABLE_CYC) ? SCAN_DIV : STABLE_CYC;
    localparam int MAXC   = (MAX_AB > RELEASE_CYC) ? MAX_AB : RELEASE_CYC;
    localparam int CW     = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_RELEASE, RELEASE_DB} state_t;

    state_t        r_state, w_state;
    logic [3:0]    r_s1, r_s2, r_pat, w_pat;
    logic [1:0]    r_col, w_col, r_row, w_row, w_hit_row;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          w_emit, w_idle;

    assign col_out = ~(4'b0001 << r_col);

    always_comb begin
        w_idle    = (r_s2 == 4'hF);
        w_hit_row = !r_s2[0] ? 2'd0 : !r_s2[1] ? 2'd1 : !r_s2[2] ? 2'd2 : 2'd3;
        w_state   = r_state;
        w_col     = r_col;
        w_cnt     = r_cnt + 1'b1;
        w_row     = r_row;
        w_pat     = r_pat;
        w_emit    = 1'b0;
        case (r_state)
            SCAN: begin
                // dwell<2 hides rows still sampled from the previous column
                if (r_cnt >= CW'(2) && !w_idle) begin
                    w_state = DEBOUNCE;
                    w_row   = w_hit_row;
                    w_pat   = r_s2;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(SCAN_DIV - 1)) begin
                    w_col = r_col + 2'd1;
                    w_cnt = '0;
                end
            end
            DEBOUNCE: begin
                if (r_s2 != r_pat) begin
                    w_state = SCAN;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(STABLE_CYC - 1)) begin
                    w_emit  = 1'b1;
                    w_state = WAIT_RELEASE;
                    w_cnt   = '0;
                end
            end
            WAIT_RELEASE: begin
                w_cnt   = '0;
                w_state = w_idle ? RELEASE_DB : WAIT_RELEASE;
            end
            RELEASE_DB: begin
                if (!w_idle) begin
                    w_state = WAIT_RELEASE;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(RELEASE_CYC - 1)) begin
                    w_state = SCAN;
                    w_col   = r_col + 2'd1;
                    w_cnt   = '0;
                end
            end
            default: begin
                w_state = SCAN;
                w_col   = 2'd0;
                w_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1      <= 4'hF;
            r_s2      <= 4'hF;
            r_state   <= SCAN;
            r_col     <= 2'd0;
            r_cnt     <= '0;
            r_row     <= 2'd0;
            r_pat     <= 4'hF;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_s1    <= row_in;
            r_s2    <= r_s1;
            r_state <= w_state;
            r_col   <= w_col;
            r_cnt   <= w_cnt;
            r_row   <= w_row;
            r_pat   <= w_pat;
            overrun <= w_emit && key_valid && !key_ready;
            if (w_emit && (!key_valid || key_ready)) begin
                key_code  <= {r_row, r_col};
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule
